// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle for the bit-serial adder controller.
// The master side supplies operands and start; the slave side returns status and result.
interface serial_add_ctrl_if #(parameter int N = 8);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial N-bit adder: one full-adder cell is reused LSB first, one bit per clock.
// The result and carry-out are registered and held until the next operation completes.
module serial_add_ctrl #(
  parameter int N = 8
) (
  input logic             clk,
  input logic             rst,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [N-1:0]  ra;
  logic [N-1:0]  rb;
  logic [N-1:0]  rs;
  logic [N-1:0]  next_rs;
  logic [N-1:0]  sum_q;
  logic [CW-1:0] count;
  logic          carry;
  logic          cout_q;
  logic          busy_q;
  logic          done_q;
  logic          cell_sum;
  logic          cell_carry;
  logic          last_bit;

  // Cell sum enters at the MSB, so after N shifts bit 0 of the result sits at rs[0].
  always_comb begin
    cell_sum   = ra[0] ^ rb[0] ^ carry;
    cell_carry = (ra[0] & rb[0]) | (ra[0] & carry) | (rb[0] & carry);
    next_rs    = (rs >> 1) | (N'(cell_sum) << (N - 1));
    last_bit   = (count == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      rs     <= '0;
      sum_q  <= '0;
      count  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            ra     <= bus.a;
            rb     <= bus.b;
            carry  <= bus.cin;
            rs     <= '0;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          rs    <= next_rs;
          carry <= cell_carry;
          // count stops at N-1 rather than wrapping when N is a power of two
          if (last_bit) begin
            sum_q  <= next_rs;
            cout_q <= cell_carry;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed checks for serial_add_ctrl at N=8 and an exhaustive sweep at N=2.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  serial_add_ctrl_if #(.N(8)) bus8 ();
  serial_add_ctrl_if #(.N(2)) bus2 ();

  serial_add_ctrl #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_add_ctrl #(.N(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Presents operands for one edge, then scrambles them so later edges cannot use them.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = c;
    tick();
    bus8.start = 1'b0;
    bus8.a     = ~a;
    bus8.b     = b ^ 8'h5A;
    bus8.cin   = ~c;
  endtask

  task automatic wait_done8(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus8.done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.sum !== 8'h00 || bus8.cout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset8: busy=%b done=%b sum=%h cout=%b, want 0 0 00 0",
               bus8.busy, bus8.done, bus8.sum, bus8.cout);
    end
    tests++;
    if (bus2.busy !== 1'b0 || bus2.done !== 1'b0 || bus2.sum !== 2'b00 || bus2.cout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset2: busy=%b done=%b sum=%b cout=%b, want 0 0 00 0",
               bus2.busy, bus2.done, bus2.sum, bus2.cout);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle_after_reset: busy=%b done=%b, want 0 0", bus8.busy, bus8.done);
    end
  endtask

  task automatic test_basic();
    int   n;
    logic busy_ok;
    launch8(8'd3, 8'd5, 1'b0);
    busy_ok = (bus8.busy === 1'b1);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus8.done === 1'b1) begin
        n = i;
        break;
      end
      if (bus8.busy !== 1'b1) busy_ok = 1'b0;
    end
    tests++;
    if (n !== 8) begin
      fails++;
      $display("[TB] FAIL basic_latency: done after %0d cycles, want 8", n);
    end
    tests++;
    if (busy_ok !== 1'b1 || bus8.busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL basic_busy: busy dropped before done (busy_ok=%b busy=%b), want 1 1",
               busy_ok, bus8.busy);
    end
    tests++;
    if (bus8.sum !== 8'd8 || bus8.cout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_result: sum=%h cout=%b, want 08 0", bus8.sum, bus8.cout);
    end
    tick();
    tests++;
    if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_pulse_end: done=%b busy=%b, want 0 0", bus8.done, bus8.busy);
    end
  endtask

  task automatic test_carry();
    logic [7:0] va [4] = '{8'hFF, 8'h7F, 8'h12, 8'hFF};
    logic [7:0] vb [4] = '{8'h01, 8'h80, 8'h34, 8'hFF};
    logic       vc [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [8:0] ve [4] = '{9'h100, 9'h100, 9'h047, 9'h1FF};
    int         n;
    for (int k = 0; k < 4; k++) begin
      launch8(va[k], vb[k], vc[k]);
      wait_done8(n);
      tests++;
      if (n !== 8 || {bus8.cout, bus8.sum} !== ve[k]) begin
        fails++;
        $display("[TB] FAIL carry[%0d]: latency=%0d result=%h, want 8 %h",
                 k, n, {bus8.cout, bus8.sum}, ve[k]);
      end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    int   pulses;
    int   first;
    logic stable;
    logic [8:0] res;
    pulses = 0;
    first  = -1;
    stable = 1'b1;
    res    = '0;
    launch8(8'd3, 8'd5, 1'b0);
    tick();
    tick();
    bus8.start = 1'b1;
    bus8.a     = 8'd1;
    bus8.b     = 8'd1;
    bus8.cin   = 1'b0;
    tick();
    bus8.start = 1'b0;
    for (int t = 5; t <= 20; t++) begin
      tick();
      if (bus8.done === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = t;
          res   = {bus8.cout, bus8.sum};
        end
      end else if (first < 0 && {bus8.cout, bus8.sum} !== 9'h1FF) begin
        stable = 1'b0;
      end
    end
    tests++;
    if (pulses !== 1 || first !== 9) begin
      fails++;
      $display("[TB] FAIL ignored_start_pulses: pulses=%0d first=%0d, want 1 9", pulses, first);
    end
    tests++;
    if (res !== 9'h008) begin
      fails++;
      $display("[TB] FAIL ignored_start_result: result=%h, want 008", res);
    end
    tests++;
    if (stable !== 1'b1) begin
      fails++;
      $display("[TB] FAIL held_result_during_run: stable=%b, want 1", stable);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    int   n;
    seen = 1'b0;
    launch8(8'd3, 8'd5, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.sum !== 8'h00 || bus8.cout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_reset: busy=%b done=%b sum=%h cout=%b, want 0 0 00 0",
               bus8.busy, bus8.done, bus8.sum, bus8.cout);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("[TB] FAIL dropped_op_activity: activity=%b, want 0", seen);
    end
    launch8(8'h10, 8'h20, 1'b1);
    wait_done8(n);
    tests++;
    if (n !== 8 || {bus8.cout, bus8.sum} !== 9'h031) begin
      fails++;
      $display("[TB] FAIL after_reset_op: latency=%0d result=%h, want 8 031",
               n, {bus8.cout, bus8.sum});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [3] = '{8'h01, 8'h80, 8'h64};
    logic [7:0] vb [3] = '{8'h02, 8'h80, 8'h32};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] ve [3] = '{9'h003, 9'h100, 9'h097};
    logic [8:0] held;
    int         k;
    int         last;
    int         unstable;
    k        = 0;
    last     = -1;
    unstable = 0;
    held     = '0;
    bus8.a     = va[0];
    bus8.b     = vb[0];
    bus8.cin   = vc[0];
    bus8.start = 1'b1;
    for (int t = 1; t <= 60 && k < 3; t++) begin
      tick();
      if (bus8.done === 1'b1) begin
        tests++;
        if ({bus8.cout, bus8.sum} !== ve[k]) begin
          fails++;
          $display("[TB] FAIL b2b_result[%0d]: result=%h, want %h", k, {bus8.cout, bus8.sum}, ve[k]);
        end
        if (last >= 0) begin
          tests++;
          if (t - last !== 10) begin
            fails++;
            $display("[TB] FAIL b2b_spacing[%0d]: spacing=%0d, want 10", k, t - last);
          end
        end
        last = t;
        held = {bus8.cout, bus8.sum};
        k++;
        if (k < 3) begin
          bus8.a   = va[k];
          bus8.b   = vb[k];
          bus8.cin = vc[k];
        end else begin
          bus8.start = 1'b0;
        end
      end else begin
        if (last >= 0 && {bus8.cout, bus8.sum} !== held) unstable++;
        if (bus8.busy === 1'b1) begin
          bus8.a   = 8'($urandom);
          bus8.b   = 8'($urandom);
          bus8.cin = 1'($urandom);
        end
      end
    end
    tests++;
    if (k !== 3) begin
      fails++;
      $display("[TB] FAIL b2b_count: completed=%0d, want 3", k);
    end
    tests++;
    if (unstable !== 0) begin
      fails++;
      $display("[TB] FAIL b2b_hold: unstable cycles=%0d, want 0", unstable);
    end
    tick();
    tick();
    tick();
    tests++;
    if (bus8.busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_idle: busy=%b, want 0", bus8.busy);
    end
  endtask

  task automatic test_exhaustive_n2();
    int         n;
    logic [2:0] want;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 2; c++) begin
          want       = 3'(a + b + c);
          bus2.a     = 2'(a);
          bus2.b     = 2'(b);
          bus2.cin   = 1'(c);
          bus2.start = 1'b1;
          tick();
          bus2.start = 1'b0;
          bus2.a     = ~2'(a);
          bus2.b     = ~2'(b);
          bus2.cin   = ~1'(c);
          n = -1;
          for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus2.done === 1'b1) begin
              n = i;
              break;
            end
          end
          tests++;
          if (n !== 2 || {bus2.cout, bus2.sum} !== want) begin
            fails++;
            $display("[TB] FAIL n2 a=%0d b=%0d cin=%0d: latency=%0d result=%b, want 2 %b",
                     a, b, c, n, {bus2.cout, bus2.sum}, want);
          end
          tick();
        end
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus8.cin   = 1'b0;
    bus2.start = 1'b0;
    bus2.a     = '0;
    bus2.b     = '0;
    bus2.cin   = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_exhaustive_n2();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
